// File: rtl/pong_sync_gen.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | Module   : pong_sync_gen                                                 |
// | Purpose  : Pong H/V counter chain with blank/sync latches and strobes.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pong_sync_gen #(
  parameter int H_TOTAL      = 455,
  parameter int H_BLANK_END  = 80,
  parameter int H_SYNC_START = 32,
  parameter int H_SYNC_END   = 64,
  parameter int V_TOTAL      = 262,
  parameter int V_BLANK_END  = 16,
  parameter int V_SYNC_START = 4,
  parameter int V_SYNC_END   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  output logic [8:0] hcnt,
  output logic [8:0] vcnt,
  output logic       hreset,
  output logic       vreset,
  output logic       hblank,
  output logic       vblank,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       csync_n,
  output logic       frame_start
);

  // Windows must start after count 0 so the reset values match the decode.
  if (H_TOTAL < 2 || H_TOTAL > 512 || V_TOTAL < 2 || V_TOTAL > 512 ||
      H_BLANK_END < 1 || H_BLANK_END >= H_TOTAL ||
      H_SYNC_START < 1 || H_SYNC_END <= H_SYNC_START || H_SYNC_END >= H_TOTAL ||
      V_BLANK_END < 1 || V_BLANK_END >= V_TOTAL ||
      V_SYNC_START < 1 || V_SYNC_END <= V_SYNC_START || V_SYNC_END >= V_TOTAL) begin : g_bad_params
    $error("pong_sync_gen: invalid timing parameter set");
  end

  localparam logic [8:0] c_H_LAST       = 9'(H_TOTAL - 1);
  localparam logic [8:0] c_V_LAST       = 9'(V_TOTAL - 1);
  localparam logic [8:0] c_H_BLANK_END  = 9'(H_BLANK_END);
  localparam logic [8:0] c_H_SYNC_START = 9'(H_SYNC_START);
  localparam logic [8:0] c_H_SYNC_END   = 9'(H_SYNC_END);
  localparam logic [8:0] c_V_BLANK_END  = 9'(V_BLANK_END);
  localparam logic [8:0] c_V_SYNC_START = 9'(V_SYNC_START);
  localparam logic [8:0] c_V_SYNC_END   = 9'(V_SYNC_END);

  logic [8:0] r_hcnt;
  logic [8:0] r_vcnt;
  logic       r_hblank;
  logic       r_vblank;
  logic       r_hsync_n;
  logic       r_vsync_n;

  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [8:0] w_hcnt_nxt;
  logic [8:0] w_vcnt_nxt;

  always_comb begin
    w_h_wrap   = (r_hcnt == c_H_LAST);
    w_v_wrap   = w_h_wrap && (r_vcnt == c_V_LAST);
    w_hcnt_nxt = w_h_wrap ? 9'd0 : r_hcnt + 9'd1;
    if (w_v_wrap) begin
      w_vcnt_nxt = 9'd0;
    end else if (w_h_wrap) begin
      w_vcnt_nxt = r_vcnt + 9'd1;
    end else begin
      w_vcnt_nxt = r_vcnt;
    end
  end

  // Flags are set/cleared on the edge the count enters/leaves the window,
  // so they track the counts with zero latency, like the original latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hcnt    <= 9'd0;
      r_vcnt    <= 9'd0;
      r_hblank  <= 1'b1;
      r_vblank  <= 1'b1;
      r_hsync_n <= 1'b1;
      r_vsync_n <= 1'b1;
    end else if (ce) begin
      r_hcnt <= w_hcnt_nxt;

      if (w_h_wrap) begin
        r_hblank <= 1'b1;
      end else if (w_hcnt_nxt == c_H_BLANK_END) begin
        r_hblank <= 1'b0;
      end

      if (w_hcnt_nxt == c_H_SYNC_START) begin
        r_hsync_n <= 1'b0;
      end else if (w_hcnt_nxt == c_H_SYNC_END) begin
        r_hsync_n <= 1'b1;
      end

      if (w_h_wrap) begin
        r_vcnt <= w_vcnt_nxt;

        if (w_v_wrap) begin
          r_vblank <= 1'b1;
        end else if (w_vcnt_nxt == c_V_BLANK_END) begin
          r_vblank <= 1'b0;
        end

        if (w_vcnt_nxt == c_V_SYNC_START) begin
          r_vsync_n <= 1'b0;
        end else if (w_vcnt_nxt == c_V_SYNC_END) begin
          r_vsync_n <= 1'b1;
        end
      end
    end
  end

  assign hcnt        = r_hcnt;
  assign vcnt        = r_vcnt;
  assign hblank      = r_hblank;
  assign vblank      = r_vblank;
  assign hsync_n     = r_hsync_n;
  assign vsync_n     = r_vsync_n;
  assign hreset      = w_h_wrap;
  assign vreset      = w_v_wrap;
  // Equal sync levels give high: horizontal pulses invert during vsync.
  assign csync_n     = ~(r_hsync_n ^ r_vsync_n);
  assign frame_start = (r_hcnt == 9'd0) && (r_vcnt == 9'd0);

endmodule
`default_nettype wire

// File: tb/tb_pong_sync_gen.sv
`default_nettype none
`timescale 1ns / 1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_pong_sync_gen                                              |
// | Purpose  : Directed self-checking bench for pong_sync_gen.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_pong_sync_gen;

  logic clk = 1'b0;
  logic reset;
  logic ce;

  logic [8:0] hcnt, vcnt;
  logic hreset, vreset, hblank, vblank, hsync_n, vsync_n, csync_n, frame_start;

  logic [8:0] s_hcnt, s_vcnt;
  logic s_hreset, s_vreset, s_hblank, s_vblank, s_hsync_n, s_vsync_n, s_csync_n, s_frame_start;

  int errors = 0;
  int checks = 0;
  int exp_h  = 0;
  int exp_v  = 0;

  always #5 clk = ~clk;

  pong_sync_gen dut (
    .clk(clk), .reset(reset), .ce(ce),
    .hcnt(hcnt), .vcnt(vcnt), .hreset(hreset), .vreset(vreset),
    .hblank(hblank), .vblank(vblank), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .csync_n(csync_n), .frame_start(frame_start)
  );

  // Shrunk timing so a whole frame and its wrap fit in a short run.
  pong_sync_gen #(
    .H_TOTAL(20), .H_BLANK_END(6), .H_SYNC_START(2), .H_SYNC_END(4),
    .V_TOTAL(12), .V_BLANK_END(4), .V_SYNC_START(1), .V_SYNC_END(2)
  ) dut_small (
    .clk(clk), .reset(reset), .ce(ce),
    .hcnt(s_hcnt), .vcnt(s_vcnt), .hreset(s_hreset), .vreset(s_vreset),
    .hblank(s_hblank), .vblank(s_vblank), .hsync_n(s_hsync_n), .vsync_n(s_vsync_n),
    .csync_n(s_csync_n), .frame_start(s_frame_start)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv();
    if (exp_h == 454) begin
      exp_h = 0;
      exp_v = (exp_v == 261) ? 0 : exp_v + 1;
    end else begin
      exp_h = exp_h + 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hcnt !== 9'd0)     begin errors++; $display("FAIL reset_hcnt: got %0d want 0", hcnt); end
    checks++; if (vcnt !== 9'd0)     begin errors++; $display("FAIL reset_vcnt: got %0d want 0", vcnt); end
    checks++; if (hblank !== 1'b1)   begin errors++; $display("FAIL reset_hblank: got %b want 1", hblank); end
    checks++; if (vblank !== 1'b1)   begin errors++; $display("FAIL reset_vblank: got %b want 1", vblank); end
    checks++; if (hsync_n !== 1'b1)  begin errors++; $display("FAIL reset_hsync_n: got %b want 1", hsync_n); end
    checks++; if (vsync_n !== 1'b1)  begin errors++; $display("FAIL reset_vsync_n: got %b want 1", vsync_n); end
    checks++; if (csync_n !== 1'b1)  begin errors++; $display("FAIL reset_csync_n: got %b want 1", csync_n); end
    checks++; if (hreset !== 1'b0)   begin errors++; $display("FAIL reset_hreset: got %b want 0", hreset); end
    checks++; if (vreset !== 1'b0)   begin errors++; $display("FAIL reset_vreset: got %b want 0", vreset); end
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL reset_frame_start: got %b want 1", frame_start); end
    reset = 1'b0;
    exp_h = 0;
    exp_v = 0;
  endtask

  task automatic test_hcount();
    int bad_cnt = 0, bad_hreset = 0, bad_fs = 0;
    for (int i = 0; i < 455; i++) begin
      if (hcnt !== 9'(i) || vcnt !== 9'd0) bad_cnt++;
      if (hreset !== (i == 454)) bad_hreset++;
      if (frame_start !== (i == 0)) bad_fs++;
      tick(); adv();
    end
    checks++; if (bad_cnt !== 0)    begin errors++; $display("FAIL line0_count: bad samples %0d want 0", bad_cnt); end
    checks++; if (bad_hreset !== 0) begin errors++; $display("FAIL line0_hreset: bad samples %0d want 0", bad_hreset); end
    checks++; if (bad_fs !== 0)     begin errors++; $display("FAIL line0_frame_start: bad samples %0d want 0", bad_fs); end
    checks++; if (hcnt !== 9'd0)    begin errors++; $display("FAIL hwrap_hcnt: got %0d want 0", hcnt); end
    checks++; if (vcnt !== 9'd1)    begin errors++; $display("FAIL hwrap_vcnt: got %0d want 1", vcnt); end
    checks++; if (hblank !== 1'b1)  begin errors++; $display("FAIL hwrap_hblank: got %b want 1", hblank); end
  endtask

  task automatic test_h_windows();
    int bad_hblank = 0, bad_hsync = 0, first_blank = -1, first_sync = -1;
    for (int h = 0; h < 455; h++) begin
      if (hblank !== (h < 80)) begin bad_hblank++; if (first_blank < 0) first_blank = h; end
      if (hsync_n !== !(h >= 32 && h < 64)) begin bad_hsync++; if (first_sync < 0) first_sync = h; end
      tick(); adv();
    end
    checks++; if (bad_hblank !== 0) begin errors++; $display("FAIL hblank_window: bad samples %0d want 0 (first hcnt %0d)", bad_hblank, first_blank); end
    checks++; if (bad_hsync !== 0)  begin errors++; $display("FAIL hsync_window: bad samples %0d want 0 (first hcnt %0d)", bad_hsync, first_sync); end
  endtask

  task automatic test_vertical();
    int bad_cnt = 0, bad_vblank = 0, bad_vsync = 0, bad_cs5 = 0, bad_cs = 0, bad_vreset = 0;
    logic in_hs;
    for (int v = 2; v < 20; v++) begin
      for (int h = 0; h < 455; h++) begin
        in_hs = (h >= 32 && h < 64);
        if (hcnt !== 9'(h) || vcnt !== 9'(v)) bad_cnt++;
        if (vblank !== (v < 16)) bad_vblank++;
        if (vsync_n !== !(v >= 4 && v < 8)) bad_vsync++;
        if (vreset !== 1'b0) bad_vreset++;
        if (v == 5) begin
          if (csync_n !== in_hs) bad_cs5++;
        end else if (v >= 4 && v < 8) begin
          if (csync_n !== in_hs) bad_cs++;
        end else begin
          if (csync_n !== !in_hs) bad_cs++;
        end
        tick(); adv();
      end
    end
    checks++; if (bad_cnt !== 0)    begin errors++; $display("FAIL vert_count: bad samples %0d want 0", bad_cnt); end
    checks++; if (bad_vblank !== 0) begin errors++; $display("FAIL vblank_window: bad samples %0d want 0", bad_vblank); end
    checks++; if (bad_vsync !== 0)  begin errors++; $display("FAIL vsync_window: bad samples %0d want 0", bad_vsync); end
    checks++; if (bad_vreset !== 0) begin errors++; $display("FAIL vreset_idle: bad samples %0d want 0", bad_vreset); end
    checks++; if (bad_cs5 !== 0)    begin errors++; $display("FAIL csync_line5: bad samples %0d want 0", bad_cs5); end
    checks++; if (bad_cs !== 0)     begin errors++; $display("FAIL csync_other: bad samples %0d want 0", bad_cs); end
  endtask

  task automatic test_ce_gating();
    int bad_cnt = 0, bad_hold = 0, bad_blank = 0;
    logic [22:0] snap;
    repeat (70) begin tick(); adv(); end
    for (int i = 0; i < 40; i++) begin
      snap = {hcnt, vcnt, hblank, vblank, hsync_n, vsync_n, csync_n};
      ce = (i % 2 == 0);
      tick();
      if (ce) adv();
      else if ({hcnt, vcnt, hblank, vblank, hsync_n, vsync_n, csync_n} !== snap) bad_hold++;
      if (hcnt !== 9'(exp_h) || vcnt !== 9'(exp_v)) bad_cnt++;
      if (hblank !== (exp_h < 80)) bad_blank++;
    end
    ce = 1'b1;
    checks++; if (bad_cnt !== 0)   begin errors++; $display("FAIL ce_count: bad samples %0d want 0", bad_cnt); end
    checks++; if (bad_hold !== 0)  begin errors++; $display("FAIL ce_hold: bad samples %0d want 0", bad_hold); end
    checks++; if (bad_blank !== 0) begin errors++; $display("FAIL ce_hblank: bad samples %0d want 0", bad_blank); end
    checks++; if (hcnt !== 9'd90)  begin errors++; $display("FAIL ce_final_hcnt: got %0d want 90", hcnt); end
  endtask

  task automatic test_async_reset();
    int n;
    n = (100 * 455 + 200) - (exp_v * 455 + exp_h);
    repeat (n) begin tick(); adv(); end
    checks++; if (hcnt !== 9'd200 || vcnt !== 9'd100) begin errors++; $display("FAIL pre_reset_pos: got %0d/%0d want 200/100", hcnt, vcnt); end
    #3 reset = 1'b1;
    #1;
    checks++; if (hcnt !== 9'd0 || vcnt !== 9'd0) begin errors++; $display("FAIL async_counts: got %0d/%0d want 0/0", hcnt, vcnt); end
    checks++; if (hblank !== 1'b1 || vblank !== 1'b1) begin errors++; $display("FAIL async_blank: got %b%b want 11", hblank, vblank); end
    checks++; if (frame_start !== 1'b1 || hsync_n !== 1'b1) begin errors++; $display("FAIL async_misc: got fs=%b hs_n=%b want 1 1", frame_start, hsync_n); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_h = 0; exp_v = 0;
    repeat (3) begin tick(); adv(); end
    checks++; if (hcnt !== 9'd3 || vcnt !== 9'd0) begin errors++; $display("FAIL restart_counts: got %0d/%0d want 3/0", hcnt, vcnt); end
  endtask

  task automatic test_small_frame();
    int bad_cnt = 0, bad_vb = 0, bad_vs = 0, bad_vr = 0, bad_hr = 0, fs_seen = 0;
    int h, v;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 240; i++) begin
      h = i % 20;
      v = i / 20;
      if (s_hcnt !== 9'(h) || s_vcnt !== 9'(v)) bad_cnt++;
      if (s_vblank !== (v < 4)) bad_vb++;
      if (s_vsync_n !== (v != 1)) bad_vs++;
      if (s_vreset !== (h == 19 && v == 11)) bad_vr++;
      if (s_hreset !== (h == 19)) bad_hr++;
      if (s_frame_start === 1'b1) fs_seen++;
      tick();
    end
    checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL frame_count: bad samples %0d want 0", bad_cnt); end
    checks++; if (bad_vb !== 0)  begin errors++; $display("FAIL frame_vblank: bad samples %0d want 0", bad_vb); end
    checks++; if (bad_vs !== 0)  begin errors++; $display("FAIL frame_vsync: bad samples %0d want 0", bad_vs); end
    checks++; if (bad_vr !== 0)  begin errors++; $display("FAIL frame_vreset: bad samples %0d want 0", bad_vr); end
    checks++; if (bad_hr !== 0)  begin errors++; $display("FAIL frame_hreset: bad samples %0d want 0", bad_hr); end
    checks++; if (fs_seen !== 1) begin errors++; $display("FAIL frame_start_count: got %0d want 1", fs_seen); end
    checks++; if (s_hcnt !== 9'd0 || s_vcnt !== 9'd0) begin errors++; $display("FAIL frame_wrap_counts: got %0d/%0d want 0/0", s_hcnt, s_vcnt); end
    checks++; if (s_hblank !== 1'b1 || s_vblank !== 1'b1) begin errors++; $display("FAIL frame_wrap_blank: got %b%b want 11", s_hblank, s_vblank); end
    checks++; if (s_frame_start !== 1'b1) begin errors++; $display("FAIL frame_start_period: got %b want 1", s_frame_start); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hcount();
    test_h_windows();
    test_vertical();
    test_ce_gating();
    test_async_reset();
    test_small_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pong_sync_gen.md
Name: pong_sync_gen

Overview:
- Horizontal/vertical timing generator for the discrete Pong core.
- Produces the H/V count buses, the reset strobes, the blanking flags and the sync pulses.
- Downstream NOR/NAND gate models decode the net, paddle, score and ball windows from these outputs.
- Models the 7493/74107 counter chain and blank/sync latches as one synchronous block on the pixel clock.

Parameters:
- H_TOTAL, 455, pixel clocks per line; hcnt runs 0..H_TOTAL-1.
- H_BLANK_END, 80, first visible hcnt; hblank is high for hcnt 0..H_BLANK_END-1.
- H_SYNC_START, 32, first hcnt with hsync asserted.
- H_SYNC_END, 64, first hcnt after hsync.
- V_TOTAL, 262, lines per frame; vcnt runs 0..V_TOTAL-1.
- V_BLANK_END, 16, first visible line.
- V_SYNC_START, 4, first vcnt with vsync asserted.
- V_SYNC_END, 8, first vcnt after vsync.

Ports:
- clk  input  1  pixel clock (7.159 MHz nominal).
- reset  input  1  asynchronous, active-high reset.
- ce  input  1  pixel clock enable; state advances only on clk rising edges with ce=1.
- hcnt  output  9  horizontal count (H1..H256 bits).
- vcnt  output  9  vertical count (V1..V256 bits).
- hreset  output  1  high while hcnt == H_TOTAL-1.
- vreset  output  1  high while vcnt == V_TOTAL-1 and hcnt == H_TOTAL-1.
- hblank  output  1  horizontal blanking, active-high.
- vblank  output  1  vertical blanking, active-high.
- hsync_n  output  1  horizontal sync, active-low.
- vsync_n  output  1  vertical sync, active-low.
- csync_n  output  1  composite sync, active-low; equals NOT(hsync XOR vsync).
- frame_start  output  1  one-ce pulse while hcnt==0 and vcnt==0.

Behaviour:
- Clocking: one clock domain. Reset is asynchronous and active-high.
- Values while reset is asserted:
  - hcnt=0, vcnt=0.
  - hblank=1, vblank=1.
  - hsync_n=1, vsync_n=1, csync_n=1.
  - hreset=0, vreset=0.
  - frame_start=1, because it is a decode of hcnt=0/vcnt=0.
- Reset mid-line or mid-frame returns all state to those values immediately. It does not wait for a clock edge.
- Counter update, on each clk edge with ce=1:
  - If hcnt==H_TOTAL-1, hcnt wraps to 0. Otherwise hcnt increments by 1.
  - vcnt increments only on the edge where hcnt wraps.
  - If that wrap also has vcnt==V_TOTAL-1, vcnt wraps to 0 as well.
- ce=0 holds every register, so all outputs are frozen.
- Width rules:
  - Counters are 9 bits, unsigned.
  - Comparisons use the full 9 bits.
  - Values at or above H_TOTAL/V_TOTAL are unreachable except via parameters. The wrap compare is equality, so such a parameter set is an elaboration error, not a runtime case.
- Blank and sync flags are registered state elements (latch models).
  - Each is updated on the same ce edge as the counters.
  - Each therefore always equals the decode of the current hcnt/vcnt. Latency is 0 cycles relative to the counts.
  - hblank=1 for hcnt in [0, H_BLANK_END-1]; set on the edge hcnt wraps to 0, cleared on the edge hcnt becomes H_BLANK_END.
  - hsync_n=0 for hcnt in [H_SYNC_START, H_SYNC_END-1].
  - vblank=1 for vcnt in [0, V_BLANK_END-1]; updated only on the hcnt wrap edge.
  - vsync_n=0 for vcnt in [V_SYNC_START, V_SYNC_END-1]; updated only on the hcnt wrap edge.
  - csync_n is combinational from the registered hsync_n and vsync_n. During vsync, horizontal pulses therefore invert (serrations).
- Strobes:
  - hreset and vreset are combinational decodes of the current counts. They are not gated by ce.
  - Downstream stages qualify them with ce.
- Simultaneous events: on the final pixel of the frame (hcnt=454, vcnt=261):
  - hreset=1 and vreset=1 together.
  - The next ce edge gives hcnt=0, vcnt=0, hblank=1, vblank=1, frame_start=1.
- Frame length: exactly H_TOTAL*V_TOTAL = 119210 ce cycles.

Test Plan:
- Reset then 455 ce pulses:
  - hcnt steps 0→454→0 and vcnt=1 after the wrap.
  - hreset is high only at hcnt=454.
- Horizontal window check:
  - hblank=1 for hcnt 0..79 and 0 at 80..454.
  - hsync_n=0 exactly for hcnt 32..63.
- Full frame, 119210 ce:
  - vblank=1 for lines 0..15.
  - vsync_n=0 for lines 4..7.
  - vreset high only at (454,261).
  - frame_start recurs after exactly 119210 ce.
- Composite sync, line 5:
  - csync_n=1 for hcnt 32..63.
  - csync_n=0 elsewhere on that line.
- ce gating: ce toggled 1/0 alternately → counts advance only on ce=1 edges; outputs constant during ce=0.
- Async reset asserted at hcnt=200, vcnt=100 between clock edges:
  - Outputs immediately become 0/0 with hblank=vblank=1.
  - After release, counting restarts from 0.
